// File: rtl/fb_rect_fill.sv
// fb_rect_fill: writes one colour into a rectangle of framebuffer words.
// Core programs the job, pulses start, and polls busy/done. The job is
// latched on start, so the input fields may change once the job is running.
// mem_addr/mem_wdata/mem_we are registered and hold steady while mem_ready
// is low; busy and done are decoded directly from the state register.
module fb_rect_fill #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int DIM_W      = 10,
    parameter int LINE_WORDS = 640
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  x0,
    input  logic [DIM_W-1:0]  y0,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    input  logic [DATA_W-1:0] color,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LINE_A = ADDR_W'(LINE_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DIM_W-1:0]  x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic [ADDR_W-1:0] row_addr_q, row_addr_d;
    logic [DIM_W-1:0]  col_q, col_d, row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] setup_addr;
    logic              last_col, last_row;

    // First pixel address of the first row. Every term is ADDR_W wide, so
    // the arithmetic wraps silently at the top of the address space.
    assign setup_addr = base_q + ADDR_W'(y0_q) * LINE_A + ADDR_W'(x0_q);
    assign last_col   = (col_q == w_q - DIM_W'(1));
    assign last_row   = (row_q == h_q - DIM_W'(1));

    // Next state: job latch, rectangle walk, and write port.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        color_d    = color_q;
        row_addr_d = row_addr_q;
        col_d      = col_q;
        row_d      = row_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        case (state_q)
            S_IDLE: begin
                // abort is ignored here, so start wins when both are high
                if (start) begin
                    base_d  = base_addr;
                    x0_d    = x0;
                    y0_d    = y0;
                    w_d     = width;
                    h_d     = height;
                    color_d = color;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    row_addr_d = setup_addr;
                    col_d      = '0;
                    row_d      = '0;
                    addr_d     = setup_addr;
                    wdata_d    = color_q;
                    if (w_q == '0 || h_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        we_d    = 1'b1;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (abort) begin
                    // a write accepted in this cycle has already landed
                    we_d    = 1'b0;
                    state_d = S_IDLE;
                end else if (mem_ready) begin
                    if (last_col) begin
                        if (last_row) begin
                            we_d    = 1'b0;
                            state_d = S_DONE;
                        end else begin
                            col_d      = '0;
                            row_d      = row_q + DIM_W'(1);
                            row_addr_d = row_addr_q + LINE_A;
                            addr_d     = row_addr_q + LINE_A;
                        end
                    end else begin
                        col_d  = col_q + DIM_W'(1);
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                we_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset clears the port and drops any fill in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            color_q    <= '0;
            row_addr_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            color_q    <= color_d;
            row_addr_q <= row_addr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign busy      = (state_q == S_SETUP) || (state_q == S_WRITE);
    assign done      = (state_q == S_DONE);

endmodule
